// File: rtl/gnrc_sdp_ram.sv
// gnrc_sdp_ram
// Simple dual-port memory responder for the gnrc memory request interface.
// It has one write port and one read port. Read data returns a fixed DELAY
// cycles after the request, and the responder sustains one read per cycle.
// The storage array is never reset. The read pipeline, the output register
// and the sticky address-error flag are all reset asynchronously.
module gnrc_sdp_ram #(
  parameter int DW       = 32,
  parameter int DP       = 512,
  parameter int DELAY    = 1,
  parameter int RDW_MODE = 0,
  parameter int AW       = $clog2(DP)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          mem_wen_i,
  input  logic [AW-1:0] mem_waddr_i,
  input  logic [DW-1:0] mem_wdata_i,
  input  logic          mem_ren_i,
  input  logic [AW-1:0] mem_raddr_i,
  output logic [DW-1:0] mem_rdata_o,
  output logic          mem_rvalid_o,
  output logic          addr_err_o,
  input  logic          err_clr_i
);

  // Depth widened by one bit so that a non-power-of-two depth is comparable.
  localparam logic [AW:0] DP_C = (AW+1)'(DP);

  logic [DW-1:0]             mem_r [DP];
  logic                      wr_ok_s;
  logic                      rd_ok_s;
  logic [DW-1:0]             launch_dat_s;
  logic [DELAY-1:0]          vld_nxt_s;
  logic [DELAY-1:0][DW-1:0]  dat_nxt_s;
  logic [DELAY-1:0]          vld_r;
  logic [DELAY-1:0][DW-1:0]  dat_r;
  logic                      err_set_s;
  logic                      err_nxt_s;
  logic                      err_r;

  assign wr_ok_s = ({1'b0, mem_waddr_i} < DP_C);
  assign rd_ok_s = ({1'b0, mem_raddr_i} < DP_C);

  // Storage update. An out-of-range write is dropped here.
  always_ff @(posedge clk_i) begin
    if (mem_wen_i && wr_ok_s) begin
      mem_r[mem_waddr_i] <= mem_wdata_i;
    end
  end

  // Select the word captured at read launch: zero when out of range, and
  // the write data when a same-address collision occurs in write-first mode.
  always_comb begin
    launch_dat_s = '0;
    if (!rd_ok_s) begin
      launch_dat_s = '0;
    end else if ((RDW_MODE != 0) && mem_wen_i && (mem_waddr_i == mem_raddr_i)) begin
      launch_dat_s = mem_wdata_i;
    end else begin
      launch_dat_s = mem_r[mem_raddr_i];
    end
  end

  // Next-state logic for the read pipeline. The last stage doubles as the
  // output register, so it holds its data whenever no valid word arrives.
  always_comb begin
    vld_nxt_s    = '0;
    dat_nxt_s    = '0;
    vld_nxt_s[0] = mem_ren_i;
    dat_nxt_s[0] = mem_ren_i ? launch_dat_s : '0;
    for (int i = 1; i < DELAY; i++) begin
      vld_nxt_s[i] = vld_r[i-1];
      dat_nxt_s[i] = dat_r[i-1];
    end
    dat_nxt_s[DELAY-1] = vld_nxt_s[DELAY-1] ? dat_nxt_s[DELAY-1] : dat_r[DELAY-1];
  end

  // Read pipeline registers. A reset discards every read that is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_r <= '0;
      dat_r <= '0;
    end else begin
      vld_r <= vld_nxt_s;
      dat_r <= dat_nxt_s;
    end
  end

  assign err_set_s = (mem_wen_i & ~wr_ok_s) | (mem_ren_i & ~rd_ok_s);

  // Sticky error next state. When a new error and a clear arrive together,
  // the new error is kept.
  always_comb begin
    err_nxt_s = err_r;
    if (err_set_s) begin
      err_nxt_s = 1'b1;
    end else if (err_clr_i) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // Address-error flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_nxt_s;
    end
  end

  assign mem_rvalid_o = vld_r[DELAY-1];
  assign mem_rdata_o  = dat_r[DELAY-1];
  assign addr_err_o   = err_r;

endmodule

// File: tb/tb_gnrc_sdp_ram.sv
// Testbench for gnrc_sdp_ram.
// It drives four differently configured instances, each with directed and
// random traffic. An in-bench memory model tracks every read as a timestamped
// queue entry. The model is compared against the DUT outputs on every cycle,
// and literal expectations pin the key scenarios.
module tb_gnrc_sdp_ram;

  typedef struct {
    int         due;
    logic [7:0] d;
    bit         kn;
  } rd_t;

  logic clk = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int P_DP    = (g < 2) ? 8 : 6;
    localparam int P_DELAY = (g == 0) ? 1 : ((g == 3) ? 4 : 3);
    localparam int P_RDW   = g % 2;
    localparam int P_AW    = $clog2(P_DP);

    logic            rst_n;
    logic            wen = 1'b0;
    logic            ren = 1'b0;
    logic            clr = 1'b0;
    logic [P_AW-1:0] waddr = '0;
    logic [P_AW-1:0] raddr = '0;
    logic [7:0]      wdata = 8'h00;
    logic [7:0]      rdata;
    logic            rvalid;
    logic            aerr;

    gnrc_sdp_ram #(
      .DW(8), .DP(P_DP), .DELAY(P_DELAY), .RDW_MODE(P_RDW)
    ) u_dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .mem_wen_i   (wen),
      .mem_waddr_i (waddr),
      .mem_wdata_i (wdata),
      .mem_ren_i   (ren),
      .mem_raddr_i (raddr),
      .mem_rdata_o (rdata),
      .mem_rvalid_o(rvalid),
      .addr_err_o  (aerr),
      .err_clr_i   (clr)
    );

    // Reference model state.
    logic [7:0] m_mem [P_DP];
    bit         m_kn  [P_DP];
    rd_t        q[$];
    bit         m_err = 1'b0;
    logic [7:0] m_last = 8'h00;
    bit         m_last_kn = 1'b1;
    int         cyc = 0;
    logic [7:0] obs_d[$];
    int         obs_t[$];
    bit         done = 1'b0;

    // Model: each read becomes a queue entry, due DELAY-1 edges after the
    // edge that launched it.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        m_err     = 1'b0;
        m_last    = 8'h00;
        m_last_kn = 1'b1;
        for (int a = 0; a < P_DP; a++) m_kn[a] = 1'b0;
      end else begin
        cyc++;
        if (ren) begin
          if (raddr >= P_DP)
            q.push_back('{cyc + P_DELAY - 1, 8'h00, 1'b1});
          else if (wen && (waddr == raddr) && (P_RDW == 1))
            q.push_back('{cyc + P_DELAY - 1, wdata, 1'b1});
          else
            q.push_back('{cyc + P_DELAY - 1, m_mem[raddr], m_kn[raddr]});
        end
        if (wen && (waddr < P_DP)) begin
          m_mem[waddr] = wdata;
          m_kn[waddr]  = 1'b1;
        end
        if ((wen && (waddr >= P_DP)) || (ren && (raddr >= P_DP))) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
      end
    end

    // Per-cycle compare of the DUT against the model, plus a monitor that
    // records completed reads.
    always @(negedge clk) begin
      bit  exp_v;
      rd_t e;
      if (!rst_n) begin
        chk($sformatf("g%0d rst rvalid", g), rvalid, 0);
        chk($sformatf("g%0d rst rdata", g), rdata, 0);
        chk($sformatf("g%0d rst aerr", g), aerr, 0);
      end else begin
        exp_v = (q.size() > 0) && (q[0].due == cyc);
        if (exp_v) begin
          e         = q.pop_front();
          m_last    = e.d;
          m_last_kn = e.kn;
        end
        chk($sformatf("g%0d rvalid c%0d", g, cyc), rvalid, exp_v);
        if (m_last_kn) chk($sformatf("g%0d rdata c%0d", g, cyc), rdata, m_last);
        chk($sformatf("g%0d aerr c%0d", g, cyc), aerr, m_err);
        if (rvalid) begin
          obs_d.push_back(rdata);
          obs_t.push_back(cyc);
        end
      end
    end

    task automatic drv(input bit we, input int wa, input int wd,
                       input bit re, input int ra, input bit cl);
      @(negedge clk);
      #1;
      wen   = we;
      waddr = wa[P_AW-1:0];
      wdata = wd[7:0];
      ren   = re;
      raddr = ra[P_AW-1:0];
      clr   = cl;
    endtask

    task automatic idle();
      drv(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    // Directed scenarios, random traffic, then a reset in mid-flight.
    initial begin
      int t0;
      bit bad;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      for (int a = 0; a < P_DP; a++) drv(1'b1, a, a * 7 + 3, 1'b0, 0, 1'b0);

      // Write then read the next cycle; the data then holds after rvalid drops.
      drv(1'b1, 3, 'hA5, 1'b0, 0, 1'b0);
      drv(1'b0, 0, 0, 1'b1, 3, 1'b0);
      repeat (P_DELAY) idle();
      chk($sformatf("g%0d t1 rvalid", g), rvalid, 1);
      chk($sformatf("g%0d t1 rdata", g), rdata, 8'hA5);
      idle();
      chk($sformatf("g%0d t1 rvalid drop", g), rvalid, 0);
      chk($sformatf("g%0d t1 rdata hold", g), rdata, 8'hA5);

      // Same-cycle write and read of one address.
      drv(1'b1, 5, 'h11, 1'b0, 0, 1'b0);
      drv(1'b1, 5, 'h22, 1'b1, 5, 1'b0);
      repeat (P_DELAY) idle();
      chk($sformatf("g%0d collide rvalid", g), rvalid, 1);
      chk($sformatf("g%0d collide rdata", g), rdata, (P_RDW == 1) ? 8'h22 : 8'h11);

      // Back-to-back reads across the whole array.
      for (int a = 0; a < P_DP; a++) drv(1'b1, a, 'h10 + a, 1'b0, 0, 1'b0);
      idle();
      obs_d.delete();
      obs_t.delete();
      t0 = 0;
      for (int a = 0; a < P_DP; a++) begin
        drv(1'b0, 0, 0, 1'b1, a, 1'b0);
        if (a == 0) t0 = cyc + 1;
      end
      repeat (P_DELAY + 2) idle();
      chk($sformatf("g%0d b2b count", g), obs_d.size(), P_DP);
      for (int i = 0; i < P_DP && i < obs_d.size(); i++) begin
        chk($sformatf("g%0d b2b data%0d", g, i), obs_d[i], 'h10 + i);
        chk($sformatf("g%0d b2b time%0d", g, i), obs_t[i], t0 + P_DELAY - 1 + i);
      end

      // A write issued after a read launches must not alter that read.
      drv(1'b1, 2, 'h01, 1'b0, 0, 1'b0);
      idle();
      obs_d.delete();
      obs_t.delete();
      drv(1'b0, 0, 0, 1'b1, 2, 1'b0);
      drv(1'b1, 2, 'h02, 1'b0, 0, 1'b0);
      repeat (P_DELAY + 1) idle();
      chk($sformatf("g%0d inflight count", g), obs_d.size(), 1);
      chk($sformatf("g%0d inflight data", g), (obs_d.size() > 0) ? obs_d[0] : 8'hEE, 8'h01);

      // Address 7, which is out of range only when the depth is 6.
      bad = (7 >= P_DP);
      drv(1'b1, 7, 'hFF, 1'b0, 0, 1'b0);
      idle();
      chk($sformatf("g%0d oor wr err", g), aerr, bad);
      drv(1'b0, 0, 0, 1'b1, 7, 1'b0);
      repeat (P_DELAY) idle();
      chk($sformatf("g%0d oor rvalid", g), rvalid, 1);
      chk($sformatf("g%0d oor rdata", g), rdata, bad ? 8'h00 : 8'hFF);
      chk($sformatf("g%0d oor err", g), aerr, bad);
      idle();
      idle();
      chk($sformatf("g%0d oor sticky", g), aerr, bad);
      drv(1'b0, 0, 0, 1'b0, 0, 1'b1);
      idle();
      chk($sformatf("g%0d oor cleared", g), aerr, 0);
      drv(1'b0, 0, 0, 1'b1, 7, 1'b1);
      idle();
      chk($sformatf("g%0d oor set wins", g), aerr, bad);
      drv(1'b0, 0, 0, 1'b0, 0, 1'b1);
      repeat (P_DELAY + 1) idle();

      // Random traffic over the full address space.
      for (int n = 0; n < 300; n++) begin
        drv(1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << P_AW) - 1)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, (1 << P_AW) - 1)), ($urandom_range(0, 7) == 0));
      end
      repeat (P_DELAY + 1) idle();

      // Reset while a read is in flight.
      drv(1'b0, 0, 0, 1'b1, 1, 1'b0);
      idle();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk($sformatf("g%0d async rvalid", g), rvalid, 0);
      chk($sformatf("g%0d async rdata", g), rdata, 0);
      chk($sformatf("g%0d async aerr", g), aerr, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      obs_d.delete();
      obs_t.delete();
      repeat (P_DELAY + 3) idle();
      chk($sformatf("g%0d post-reset rvalid count", g), obs_d.size(), 0);
      done = 1'b1;
    end
  end

  // Bounded wait for every instance to finish, then print the summary.
  initial begin
    bit all_done;
    fork
      wait (g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done);
      #(1_000_000);
    join_any
    disable fork;
    all_done = g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done;
    chk("completion", all_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
